// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   localparam int          LAT_CNT_W       = 4;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/load_extend.sv
// Byte/word select for load data: a byte load takes read bits [7:0] and
// sign- or zero-extends them; a word load passes the data through.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic        byte_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   // Extension fill bit is the byte's MSB only for signed byte loads.
   always_comb begin
      data_o = data_i;
      if (byte_i) begin
         data_o = {{24{~unsigned_i & data_i[7]}}, data_i[7:0]};
      end else begin
         data_o = data_i;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, IDLE -> ACCESS -> RESP.
// Build option LSU_ALIGN_CHECK_EN: misaligned word requests return resp_err
// without touching memory; otherwise word addresses are forced word-aligned.
// The memory byte-select port is named mem_byte because byte is a keyword.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              mem_byte,
   input  logic [DATA_W-1:0] read_data
);

   localparam logic [LAT_CNT_W-1:0] LAT_INIT   = LAT_CNT_W'(MEM_LATENCY - 1);
   localparam logic [ADDR_W-1:0]    ALIGN_MASK = ~ADDR_W'(~WORD_ALIGN_MASK);

   lsu_state_e             state_q;
   logic [LAT_CNT_W-1:0]   cnt_q;
   logic                   write_q;
   logic                   byte_q;
   logic                   unsigned_q;
   logic [ADDR_W-1:0]      address_q;
   logic [DATA_W-1:0]      write_data_q;
   logic                   mem_read_q;
   logic                   mem_write_q;
   logic                   resp_valid_q;
   logic [DATA_W-1:0]      resp_rdata_q;
   logic [DATA_W-1:0]      resp_rdata_d;
   logic                   misalign_s;

   load_extend u_load_extend (
      .data_i     (read_data),
      .byte_i     (byte_q),
      .unsigned_i (unsigned_q),
      .data_o     (resp_rdata_d)
   );

`ifdef LSU_ALIGN_CHECK_EN
   logic err_q;

   assign misalign_s = ~req_byte & (req_addr[1:0] != 2'b00);
   assign resp_err   = err_q;

   // Error flag is decided at acceptance and held through the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state_q == ST_IDLE && req_valid) begin
         err_q <= misalign_s;
      end
   end
`else
   assign misalign_s = 1'b0;
   assign resp_err   = 1'b0;
`endif

   // Request/response FSM with registered memory strobes and response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         byte_q       <= 1'b0;
         unsigned_q   <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  write_q    <= req_write;
                  byte_q     <= req_byte;
                  unsigned_q <= req_unsigned;
                  cnt_q      <= LAT_INIT;
                  if (misalign_s) begin
                     resp_rdata_q <= '0;
                     resp_valid_q <= 1'b1;
                     state_q      <= ST_RESP;
                  end else begin
                     address_q   <= req_byte ? req_addr : (req_addr & ALIGN_MASK);
                     mem_read_q  <= ~req_write;
                     mem_write_q <= req_write;
                     if (req_write) begin
                        write_data_q <= req_wdata;
                     end
                     state_q <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               // Stores take a single cycle; loads wait out the counter.
               if (write_q) begin
                  mem_write_q  <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else if (cnt_q == '0) begin
                  mem_read_q   <= 1'b0;
                  resp_rdata_q <= resp_rdata_d;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - LAT_CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               mem_read_q   <= 1'b0;
               mem_write_q  <= 1'b0;
               resp_valid_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = rst_n & (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign address    = address_q;
   assign write_data = write_data_q;
   assign MemRead    = mem_read_q;
   assign MemWrite   = mem_write_q;
   assign mem_byte   = byte_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench: two LSUs (MEM_LATENCY 1 and 3) on a shared byte memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1_n, rst3_n, v1, v3;
   logic        req_write, req_byte, req_unsigned, resp_ready;
   logic [31:0] req_addr, req_wdata;

   logic        rdy1, rv1, err1, mr1, mw1, mb1;
   logic [31:0] rdata1, addr1, wd1, rd1;
   logic        rdy3, rv3, err3, mr3, mw3, mb3;
   logic [31:0] rdata3, addr3, wd3, rd3;

   logic [7:0]  mem [0:255];
   logic        s;

   load_store_unit #(.MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .req_valid(v1), .req_ready(rdy1),
      .req_write(req_write), .req_byte(req_byte), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
      .resp_ready(resp_ready), .resp_rdata(rdata1), .resp_err(err1),
      .address(addr1), .write_data(wd1), .MemRead(mr1), .MemWrite(mw1),
      .mem_byte(mb1), .read_data(rd1));

   load_store_unit #(.MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(rdy3),
      .req_write(req_write), .req_byte(req_byte), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3),
      .resp_ready(resp_ready), .resp_rdata(rdata3), .resp_err(err3),
      .address(addr3), .write_data(wd3), .MemRead(mr3), .MemWrite(mw3),
      .mem_byte(mb3), .read_data(rd3));

   // Byte reads put junk in [31:8] so the extension must ignore it.
   assign rd1 = mb1 ? {24'h5A5A5A, mem[addr1[7:0]]} :
                {mem[addr1[7:0] + 8'd3], mem[addr1[7:0] + 8'd2], mem[addr1[7:0] + 8'd1], mem[addr1[7:0]]};
   assign rd3 = mb3 ? {24'h5A5A5A, mem[addr3[7:0]]} :
                {mem[addr3[7:0] + 8'd3], mem[addr3[7:0] + 8'd2], mem[addr3[7:0] + 8'd1], mem[addr3[7:0]]};

   always @(posedge clk) begin
      if (mw1) begin
         mem[addr1[7:0]] <= wd1[7:0];
         if (!mb1) begin
            mem[addr1[7:0] + 8'd1] <= wd1[15:8];
            mem[addr1[7:0] + 8'd2] <= wd1[23:16];
            mem[addr1[7:0] + 8'd3] <= wd1[31:24];
         end
      end
      if (mw3) begin
         mem[addr3[7:0]] <= wd3[7:0];
         if (!mb3) begin
            mem[addr3[7:0] + 8'd1] <= wd3[15:8];
            mem[addr3[7:0] + 8'd2] <= wd3[23:16];
            mem[addr3[7:0] + 8'd3] <= wd3[31:24];
         end
      end
   end

   logic        m_rdy, m_rv, m_err, m_mr, m_mw, m_mb;
   logic [31:0] m_rdata, m_addr, m_wd;
   assign m_rdy   = s ? rdy3   : rdy1;
   assign m_rv    = s ? rv3    : rv1;
   assign m_err   = s ? err3   : err1;
   assign m_mr    = s ? mr3    : mr1;
   assign m_mw    = s ? mw3    : mw1;
   assign m_mb    = s ? mb3    : mb1;
   assign m_rdata = s ? rdata3 : rdata1;
   assign m_addr  = s ? addr3  : addr1;
   assign m_wd    = s ? wd3    : wd1;

   typedef struct {
      logic        wr;
      logic        by;
      logic        un;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vt [0:11];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut=%0d actual=%h required=%h", name, s, act, exp);
      end
   endtask

   task automatic txn(input vec_t v, input bit stall);
      int          cyc, nr, nw, ml, exp_lat;
      logic        skip;
      logic [31:0] ea, held;
      ml = s ? 3 : 1;
`ifdef LSU_ALIGN_CHECK_EN
      skip = !v.by && (v.addr[1:0] != 2'b00);
`else
      skip = 1'b0;
`endif
      ea = v.by ? v.addr : {v.addr[31:2], 2'b00};
      @(negedge clk);
      chk("req_ready_idle", {31'd0, m_rdy}, 32'd1);
      req_write = v.wr; req_byte = v.by; req_unsigned = v.un;
      req_addr = v.addr; req_wdata = v.wdata;
      if (s) v3 = 1'b1; else v1 = 1'b1;
      @(posedge clk);
      #1;
      v1 = 1'b0; v3 = 1'b0;
      cyc = 0; nr = 0; nw = 0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         chk("strobe_excl", {31'd0, m_mr & m_mw}, 32'd0);
         if (m_mr) begin
            nr++;
            chk("rd_addr", m_addr, ea);
            chk("rd_byte", {31'd0, m_mb}, {31'd0, v.by});
         end
         if (m_mw) begin
            nw++;
            chk("wr_addr", m_addr, ea);
            chk("wr_data", m_wd, v.wdata);
            chk("wr_byte", {31'd0, m_mb}, {31'd0, v.by});
         end
         if (m_rv) break;
         chk("req_ready_busy", {31'd0, m_rdy}, 32'd0);
      end
      exp_lat = skip ? 1 : (v.wr ? 2 : ml + 1);
      chk("latency", cyc, exp_lat);
      chk("mem_reads", nr, (skip || v.wr) ? 0 : ml);
      chk("mem_writes", nw, (!skip && v.wr) ? 1 : 0);
      chk("rdata", m_rdata, v.exp_rdata);
      chk("err", {31'd0, m_err}, {31'd0, v.exp_err});
      if (stall) begin
         held = m_rdata;
         for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
               req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
               v3 = 1'b1;
            end
            @(negedge clk);
            v3 = 1'b0;
            chk("stall_valid", {31'd0, m_rv}, 32'd1);
            chk("stall_rdata", m_rdata, held);
            chk("stall_ready", {31'd0, m_rdy}, 32'd0);
            chk("stall_strobes", {30'd0, m_mr, m_mw}, 32'd0);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("resp_drop", {31'd0, m_rv}, 32'd0);
      chk("req_ready_back", {31'd0, m_rdy}, 32'd1);
      if (stall) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ignored_req", {30'd0, m_mr, m_mw}, 32'd0);
         end
      end
   endtask

   initial begin
      vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
      vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0F, 32'h12345680, 32'h0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h0F, 32'h0, 32'hFFFFFF80, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h0F, 32'h0, 32'h00000080, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h07, 32'h000000AB, 32'h0, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 1'b1, 32'h07, 32'h0, 32'h000000AB, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h07, 32'h0, 32'hFFFFFFAB, 1'b0};
`ifdef LSU_ALIGN_CHECK_EN
      vt[10] = '{1'b0, 1'b0, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1};
`else
      vt[10] = '{1'b0, 1'b0, 1'b0, 32'h12, 32'h0, 32'hDEADBEEF, 1'b0};
`endif
      vt[11] = '{1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0};

      s = 1'b0;
      rst1_n = 1'b0; rst3_n = 1'b0; v1 = 1'b0; v3 = 1'b0;
      req_write = 1'b0; req_byte = 1'b0; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
      #1;
      chk("rst_req_ready", {31'd0, rdy1}, 32'd0);
      chk("rst_outputs", {26'd0, rv1, err1, mr1, mw1, mb1, rdy3}, 32'd0);
      chk("rst_address", addr1, 32'h0);
      repeat (2) @(negedge clk);
      rst1_n = 1'b1; rst3_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready1", {31'd0, rdy1}, 32'd1);
      chk("post_rst_ready3", {31'd0, rdy3}, 32'd1);

      for (int d = 0; d < 2; d++) begin
         s = (d == 1);
         for (int i = 0; i < 12; i++) txn(vt[i], 1'b0);
      end

      s = 1'b1;
      txn(vt[2], 1'b1);

      // Reset during the second ACCESS cycle of a latency-3 load.
      @(negedge clk);
      req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h10; v3 = 1'b1;
      @(posedge clk);
      #1;
      v3 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_access_read", {31'd0, mr3}, 32'd1);
      rst3_n = 1'b0;
      #1;
      chk("async_rst_strobe", {31'd0, mr3}, 32'd0);
      chk("async_rst_address", addr3, 32'h0);
      chk("async_rst_flags", {29'd0, rv3, rdy3, mw3}, 32'd0);
      @(negedge clk);
      rst3_n = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", {31'd0, rdy3}, 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("no_resp_after_rst", {30'd0, rv3, mr3}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: the block that drives `data_memory`.
- Accepts one load/store request at a time from the pipeline MEM stage over a valid/ready handshake.
- Sequences `MemRead`/`MemWrite`/`address`/`write_data`/`byte` to the memory over a fixed access latency.
- Returns load data (byte loads sign- or zero-extended) on a valid/ready response channel.

Parameters:
- MEM_LATENCY, 1: cycles `MemRead`/`address` are held before `read_data` is sampled; legal values 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; fixed at 32 for the byte-lane rules below.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_write  input  1  1 = store, 0 = load
- req_byte  input  1  1 = byte access, 0 = word access
- req_unsigned  input  1  byte load zero-extends when 1, sign-extends when 0
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data; byte stores use bits [7:0]
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  DATA_W  load result; 0 for stores
- resp_err  output  1  access error (see Optional Feature)
- address  output  ADDR_W  to memory
- write_data  output  DATA_W  to memory
- MemRead  output  1  to memory
- MemWrite  output  1  to memory
- byte  output  1  to memory, byte-access select
- read_data  input  DATA_W  from memory; byte reads return the byte in [7:0]

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, except `req_ready`, which is 1 once `rst_n` is high.
  - Any in-flight transaction is dropped with no response.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1 and memory strobes are 0.
  - On `req_valid`&&`req_ready`, register addr/wdata/write/byte/unsigned, load the latency counter and go to ACCESS.
- ACCESS, load:
  - `MemRead`=1, with `address`/`byte` held from the registered request, for exactly MEM_LATENCY cycles.
  - On the last cycle, `read_data` is registered (extended if byte) into `resp_rdata`; next state is RESP.
- ACCESS, store:
  - `MemWrite`=1 for exactly one cycle regardless of MEM_LATENCY, with `write_data`=`req_wdata` and `byte`=`req_byte`; next state is RESP.
  - `MemRead` stays 0.
- Strobe exclusivity: `MemRead` and `MemWrite` are never 1 in the same cycle. Both are 0 outside ACCESS.
- RESP:
  - `resp_valid`=1; `resp_rdata`/`resp_err` are stable until `resp_ready`=1, then the next state is IDLE.
  - `req_ready`=0 in ACCESS and RESP.
- Latency (handshake in cycle 0):
  - Load: `resp_valid` rises in cycle MEM_LATENCY+1.
  - Store: `resp_valid` rises in cycle 2.
- Byte extension: sign extension copies `read_data[7]` into bits [31:8]; unsigned loads zero-fill [31:8].
- Word loads pass `read_data` through unchanged.
- Word access with `req_addr[1:0]`≠0 is handled per the Optional Feature.
- `address`/`write_data` hold their last values when idle; the memory ignores them because both strobes are 0.
- The counter counts down from MEM_LATENCY-1 to 0 and is 4 bits wide; it never wraps.
- `req_*` inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: a misaligned word request produces no memory access.
  - Both strobes stay 0.
  - The FSM goes IDLE→RESP directly, with `resp_err`=1 and `resp_rdata`=0.
- Undefined:
  - `address[1:0]` is forced to 00 for word accesses; the access proceeds normally.
  - `resp_err` is tied to 0.

Decomposition:
- Package `lsu_pkg` holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - `LAT_CNT_W`=4;
  - `WORD_ALIGN_MASK`=32'hFFFF_FFFC.
- One sub-module, `load_extend`: combinational byte/word select plus sign/zero extension (inputs: data, byte, unsigned_flag).

Test Plan:
- Word load, MEM_LATENCY=1: memory holds 32'hDEADBEEF at 0x10; request load 0x10 at cycle 0 → `MemRead`=1 in cycle 1 only, `resp_valid` in cycle 2, `resp_rdata`=32'hDEADBEEF, `resp_err`=0.
- Byte loads from 0x0F holding 8'h80:
  - `req_unsigned`=0 → `resp_rdata`=32'hFFFFFF80;
  - `req_unsigned`=1 → 32'h00000080;
  - `byte`=1 during ACCESS in both cases.
- Store then load: store word 32'h12345678 to 0x20 → `MemWrite` high exactly 1 cycle with `write_data`=32'h12345678; a following load of 0x20 returns 32'h12345678. Byte store of 32'h000000AB to 0x07 then byte load unsigned → 32'h000000AB.
- Backpressure, MEM_LATENCY=3: `resp_ready` held 0 for 5 cycles → `MemRead` high exactly 3 cycles; `resp_valid` and `resp_rdata` stable for 5 cycles; `req_ready`=0 throughout; a `req_valid` pulse during this window is ignored.
- Reset mid-access: assert `rst_n`=0 during the 2nd ACCESS cycle of a MEM_LATENCY=3 load → all outputs 0 immediately (asynchronous); after release `req_ready`=1 and no `resp_valid` appears.
- Misaligned word load at 0x12:
  - with LSU_ALIGN_CHECK_EN → no strobe, `resp_err`=1, `resp_rdata`=0;
  - without it → `address`=0x10, normal data returned, `resp_err`=0.
